mpsoc_cpu1_ocimem_monitor: RTL and testbench

- Sits directly downstream of the cpu1 JTAG debug wrapper, in the system clock domain.
- Consumes the wrapper's jdo and take_*_ocimem_* pulses, turns them into single-word read and write transfers on an Avalon-style master port to the debug/OCI memory.
- Returns MonDReg, monitor_ready and monitor_error to the wrapper, closing the host monitor loop.
- Holds an auto-incrementing word address register so that the host can stream bursts.

---
 rtl/ocimem_monitor_pkg.sv | 31 +++
 rtl/ocimem_timeout_ctr.sv | 30 +++
 rtl/mpsoc_cpu1_ocimem_monitor.sv | 164 ++++++++++++++++
 tb/tb_mpsoc_cpu1_ocimem_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocimem_monitor_pkg.sv
// Shared types and constants for the cpu1 OCI memory monitor.
//   state_e    : transfer FSM states
//   cmd_e      : decoded host command after priority resolution
//   decode_cmd : resolves coincident take_* pulses (load > write > read)
package ocimem_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_WRITE,
        CMD_READ
    } cmd_e;

    localparam int JDO_RD_ON_LOAD  = 34;
    localparam int JDO_CLR_ERR     = 35;
    localparam int DEFAULT_TIMEOUT = 255;

    function automatic cmd_e decode_cmd(input logic a, input logic b, input logic n);
        if (a)      return CMD_LOAD;
        else if (b) return CMD_WRITE;
        else if (n) return CMD_READ;
        else        return CMD_NONE;
    endfunction

endpackage

// File: rtl/ocimem_timeout_ctr.sv
// Saturating stall counter for one memory transfer.
//   clk, reset : system clock, synchronous active-high reset
//   i_clr      : restart the count (transfer issue)
//   i_en       : count this cycle (slave stalling)
//   o_expired  : this stall cycle is the MAX-th one; abort on this edge
module ocimem_timeout_ctr #(
    parameter  int MAX   = 255,
    localparam int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_count <= '0;
        else if (i_en && r_count != CNT_W'(MAX))
            r_count <= r_count + CNT_W'(1);
    end

    // Fires on the cycle whose increment would bring the count to MAX, so the
    // request is visible for exactly MAX stalled cycles before it is dropped.
    assign o_expired = i_en && (r_count == CNT_W'(MAX - 1));

endmodule

// File: rtl/mpsoc_cpu1_ocimem_monitor.sv
// Host monitor bridge: turns JTAG wrapper take_* pulses into single-word
// Avalon-style reads/writes on the OCI memory and reports status back.
//   clk, reset              : system clock, synchronous active-high reset
//   jdo                     : JTAG data word (address, flags, write data)
//   take_action_ocimem_a    : load address / flags (optional read-on-load)
//   take_action_ocimem_b    : write jdo[31:0] at the address register
//   take_no_action_ocimem_a : read at the address register
//   MonDReg, monitor_ready, monitor_error : status back to the wrapper
//   mem_*                   : memory master port
module mpsoc_cpu1_ocimem_monitor
    import ocimem_monitor_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest
);

    state_e            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [31:0]       r_mon_dreg,  w_mon_dreg_nxt;
    logic [31:0]       r_wdata,     w_wdata_nxt;
    logic              r_ready,     w_ready_nxt;
    logic              r_error,     w_error_nxt;
    logic              r_mem_read,  w_mem_read_nxt;
    logic              r_mem_write, w_mem_write_nxt;
    logic              w_ctr_clr;
    logic              w_ctr_en;
    logic              w_expired;
    cmd_e              w_cmd;
    logic              w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37:36], jdo[33:32]};
    assign w_cmd        = decode_cmd(take_action_ocimem_a, take_action_ocimem_b,
                                     take_no_action_ocimem_a);
    assign w_ctr_en     = (r_state != IDLE) && mem_waitrequest;

    ocimem_timeout_ctr #(.MAX(TIMEOUT)) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_ctr_clr),
        .i_en      (w_ctr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mon_dreg  <= '0;
            r_wdata     <= '0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mon_dreg  <= w_mon_dreg_nxt;
            r_wdata     <= w_wdata_nxt;
            r_ready     <= w_ready_nxt;
            r_error     <= w_error_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mon_dreg_nxt  = r_mon_dreg;
        w_wdata_nxt     = r_wdata;
        w_ready_nxt     = r_ready;
        w_error_nxt     = r_error;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_ctr_clr       = 1'b0;

        unique case (r_state)
            IDLE: begin
                unique case (w_cmd)
                    CMD_LOAD: begin
                        w_addr_nxt = jdo[ADDR_W-1:0];
                        if (jdo[JDO_CLR_ERR])
                            w_error_nxt = 1'b0;
                        if (jdo[JDO_RD_ON_LOAD]) begin
                            w_mem_read_nxt = 1'b1;
                            w_mem_addr_nxt = jdo[ADDR_W-1:0];
                            w_ready_nxt    = 1'b0;
                            w_ctr_clr      = 1'b1;
                            w_state_nxt    = READ;
                        end
                    end
                    CMD_WRITE: begin
                        w_wdata_nxt     = jdo[31:0];
                        w_mem_write_nxt = 1'b1;
                        w_mem_addr_nxt  = r_addr;
                        w_ready_nxt     = 1'b0;
                        w_ctr_clr       = 1'b1;
                        w_state_nxt     = WRITE;
                    end
                    CMD_READ: begin
                        w_mem_read_nxt = 1'b1;
                        w_mem_addr_nxt = r_addr;
                        w_ready_nxt    = 1'b0;
                        w_ctr_clr      = 1'b1;
                        w_state_nxt    = READ;
                    end
                    default: ;
                endcase
            end
            READ, WRITE: begin
                // Host issued a command while busy: drop it and flag an overrun,
                // except an error-clear load, which is dropped without flagging.
                if (w_cmd != CMD_NONE && !(w_cmd == CMD_LOAD && jdo[JDO_CLR_ERR]))
                    w_error_nxt = 1'b1;

                if (!mem_waitrequest) begin
                    if (r_state == READ)
                        w_mon_dreg_nxt = mem_readdata;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_addr_nxt      = r_addr + ADDR_W'(1);
                    w_ready_nxt     = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (w_expired) begin
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_error_nxt     = 1'b1;
                    w_ready_nxt     = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;
    assign mem_address   = r_mem_addr;
    assign mem_writedata = r_wdata;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;

endmodule

// File: tb/tb_mpsoc_cpu1_ocimem_monitor.sv
// Scoreboard bench: stimulus pushes the expected memory transfer and final
// status for each operation; a monitor rebuilds each transfer from the port
// activity and compares it when the request drops.
module tb_mpsoc_cpu1_ocimem_monitor;

    logic        clk, reset;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tn_a;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;

    mpsoc_cpu1_ocimem_monitor #(.ADDR_W(8), .TIMEOUT(4)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .mem_address             (mem_address),
        .mem_writedata           (mem_writedata),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest)
    );

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        int          len;
        logic        acc;
        logic [31:0] mondreg;
        logic        err;
    } op_t;

    op_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  stall_left = 0;
    int  op_idx = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input int len, input logic acc, input logic [31:0] md, input logic e);
        op_t o;
        o.is_wr = w; o.addr = a; o.data = d; o.len = len;
        o.acc = acc; o.mondreg = md; o.err = e;
        exp_q.push_back(o);
    endtask

    task automatic pulse(input logic a, input logic b, input logic n, input logic [37:0] j);
        @(negedge clk);
        ta_a = a; ta_b = b; tn_a = n; jdo = j;
        @(negedge clk);
        ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0; jdo = '0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!monitor_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", {63'd0, monitor_ready}, 64'd1);
    endtask

    // Slave model and transfer monitor. The stall decision is made just after
    // the edge; the monitor samples once the stall input has settled.
    op_t obs;
    logic busy = 1'b0;
    logic stable;
    always @(posedge clk) begin
        #1;
        if ((mem_read || mem_write) && stall_left > 0) begin
            mem_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mem_waitrequest = 1'b0;
        end
        #1;
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (mem_read && mem_write)
                chk("rd_wr_exclusive", 64'd1, 64'd0);
            if (mem_read || mem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    obs.is_wr = mem_write; obs.addr = mem_address;
                    obs.len = 0; obs.acc = 1'b0; obs.data = '0;
                    stable = 1'b1;
                end else if (mem_address != obs.addr || mem_write != obs.is_wr) begin
                    stable = 1'b0;
                end
                obs.len++;
                if (!mem_waitrequest && !obs.acc) begin
                    obs.acc  = 1'b1;
                    obs.data = mem_write ? mem_writedata : mem_readdata;
                end
            end else if (busy) begin
                op_t e;
                busy = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_op", {56'd0, obs.addr}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_kind",   op_idx), {63'd0, obs.is_wr}, {63'd0, e.is_wr});
                    chk($sformatf("op%0d_addr",   op_idx), {56'd0, obs.addr},  {56'd0, e.addr});
                    chk($sformatf("op%0d_data",   op_idx), {32'd0, obs.data},  {32'd0, e.data});
                    chk($sformatf("op%0d_len",    op_idx), 64'(obs.len),       64'(e.len));
                    chk($sformatf("op%0d_acc",    op_idx), {63'd0, obs.acc},   {63'd0, e.acc});
                    chk($sformatf("op%0d_stable", op_idx), {63'd0, stable},    64'd1);
                    chk($sformatf("op%0d_mondreg",op_idx), {32'd0, MonDReg},   {32'd0, e.mondreg});
                    chk($sformatf("op%0d_err",    op_idx), {63'd0, monitor_error}, {63'd0, e.err});
                    chk($sformatf("op%0d_ready",  op_idx), {63'd0, monitor_ready}, 64'd1);
                end
                op_idx++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
        mem_readdata = '0; mem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_ready",   {63'd0, monitor_ready}, 64'd1);
        chk("rst_error",   {63'd0, monitor_error}, 64'd0);
        chk("rst_mondreg", {32'd0, MonDReg}, 64'd0);
        chk("rst_req",     {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_addr",    {56'd0, mem_address}, 64'd0);
        chk("rst_wdata",   {32'd0, mem_writedata}, 64'd0);

        // Load 0x10, then write; ready back two cycles after the pulse
        pulse(1, 0, 0, 38'h10);
        chk("load_no_req", {62'd0, mem_read, mem_write}, 64'd0);
        chk("load_ready",  {63'd0, monitor_ready}, 64'd1);
        push(1, 8'h10, 32'hCAFEF00D, 1, 1, 32'h0, 0);
        pulse(0, 1, 0, 38'hCAFEF00D);
        chk("wr_busy", {63'd0, monitor_ready}, 64'd0);
        @(negedge clk);
        chk("wr_ready_2cyc", {63'd0, monitor_ready}, 64'd1);

        // Read at 0x11 with 3 stall cycles
        mem_readdata = 32'h12345678; stall_left = 3;
        push(0, 8'h11, 32'h12345678, 4, 1, 32'h12345678, 0);
        pulse(0, 0, 1, 38'h0);
        wait_ready();

        // Address advanced to 0x12
        mem_readdata = 32'hA5A5A5A5; stall_left = 0;
        push(0, 8'h12, 32'hA5A5A5A5, 1, 1, 32'hA5A5A5A5, 0);
        pulse(0, 0, 1, 38'h0);
        wait_ready();

        // Wrap 0xFF -> 0x00
        pulse(1, 0, 0, 38'hFF);
        push(1, 8'hFF, 32'h11111111, 1, 1, 32'hA5A5A5A5, 0);
        pulse(0, 1, 0, 38'h11111111);
        wait_ready();
        push(1, 8'h00, 32'h22222222, 1, 1, 32'hA5A5A5A5, 0);
        pulse(0, 1, 0, 38'h22222222);
        wait_ready();

        // Read-on-load at 0x40, one stall
        mem_readdata = 32'hDEADBEEF; stall_left = 1;
        push(0, 8'h40, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 0);
        pulse(1, 0, 0, 38'h04_0000_0040);
        wait_ready();

        // Timeout at 0x41: 4 stalled cycles, then dropped
        mem_readdata = 32'h99999999; stall_left = 1000;
        push(0, 8'h41, 32'h0, 4, 0, 32'hDEADBEEF, 1);
        pulse(0, 0, 1, 38'h0);
        wait_ready();
        stall_left = 0;
        // Address unchanged, error sticky
        mem_readdata = 32'h0BADF00D;
        push(0, 8'h41, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 1);
        pulse(0, 0, 1, 38'h0);
        wait_ready();
        pulse(1, 0, 0, 38'h08_0000_0030);
        chk("clr_error", {63'd0, monitor_error}, 64'd0);

        // Overrun: write pulse during a stalled read
        mem_readdata = 32'h55AA55AA; stall_left = 3;
        push(0, 8'h30, 32'h55AA55AA, 4, 1, 32'h55AA55AA, 1);
        pulse(0, 0, 1, 38'h0);
        pulse(0, 1, 0, 38'h77777777);
        wait_ready();

        // Error-clear load while busy: ignored, no reload
        mem_readdata = 32'h66666666; stall_left = 3;
        push(0, 8'h31, 32'h66666666, 4, 1, 32'h66666666, 1);
        pulse(0, 0, 1, 38'h0);
        pulse(1, 0, 0, 38'h08_0000_0080);
        wait_ready();
        mem_readdata = 32'h32323232; stall_left = 0;
        push(0, 8'h32, 32'h32323232, 1, 1, 32'h32323232, 1);
        pulse(0, 0, 1, 38'h0);
        wait_ready();

        // Priority: all three pulses together -> load only
        pulse(1, 0, 0, 38'h08_0000_0050);
        chk("clr_error2", {63'd0, monitor_error}, 64'd0);
        pulse(1, 1, 1, 38'h60);
        chk("prio_no_req", {62'd0, mem_read, mem_write}, 64'd0);
        chk("prio_ready",  {63'd0, monitor_ready}, 64'd1);
        mem_readdata = 32'h600D600D;
        push(0, 8'h60, 32'h600D600D, 1, 1, 32'h600D600D, 0);
        pulse(0, 0, 1, 38'h0);
        wait_ready();

        // Reset mid-transfer: request dropped, no completion reported
        stall_left = 1000;
        pulse(0, 0, 1, 38'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stall_left = 0;
        chk("mid_rst_req",     {62'd0, mem_read, mem_write}, 64'd0);
        chk("mid_rst_ready",   {63'd0, monitor_ready}, 64'd1);
        chk("mid_rst_mondreg", {32'd0, MonDReg}, 64'd0);
        mem_readdata = 32'h00000001;
        push(0, 8'h00, 32'h1, 1, 1, 32'h1, 0);
        pulse(0, 0, 1, 38'h0);
        wait_ready();

        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
